segre_dmmu_responder: RTL and testbench

Data-side MMU responder serving the MEM pipeline's cache-miss and dirty-writeback requests. It sits between the MEM pipeline's MMU port and the memory interface. It accepts line-fill misses and victim writebacks, sequences them onto a single-ported memory bus, and returns the filled lane with its address and a replacement index. That response is the producer of the data-ready, address, lane-data and LRU-index inputs the pipeline consumes.

---
 rtl/segre_dmmu_responder.sv | 158 +++++++++++++++
 tb/tb_segre_dmmu_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dmmu_responder.sv
// Data-side MMU responder: one-entry writeback buffer plus line-fill sequencer on a single-ported memory bus.
// Optional build macro SEGRE_DMMU_WB_FWD_EN: a fill that hits the buffered victim line is served from the buffer.
module segre_dmmu_responder #(
    parameter int ADDR_W  = 32,
    parameter int LANE_W  = 128,
    parameter int INDEX_W = 2
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    input  logic               miss_i,
    input  logic [ADDR_W-1:0]  miss_addr_i,
    input  logic               wb_i,
    input  logic [ADDR_W-1:0]  wb_addr_i,
    input  logic [LANE_W-1:0]  wb_data_i,
    output logic               wb_ready_o,
    output logic               data_rdy_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [LANE_W-1:0]  data_o,
    output logic [INDEX_W-1:0] lru_index_o,
    output logic               busy_o,
    output logic               mem_rd_req_o,
    output logic               mem_wr_req_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [LANE_W-1:0]  mem_wr_data_o,
    input  logic               mem_ack_i,
    input  logic [LANE_W-1:0]  mem_rd_data_i
);

    localparam int OFF = $clog2(LANE_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 wb_valid_r;
    logic [ADDR_W-1:0]    wb_addr_r;
    logic [LANE_W-1:0]    wb_data_r;
    logic [ADDR_W-1:0]    miss_addr_r;
    logic                 miss_pend_r;
    logic [ADDR_W-1:0]    resp_addr_r;
    logic [LANE_W-1:0]    resp_data_r;
    logic [INDEX_W-1:0]   victim_r;
    logic                 fwd_hit_s;

`ifdef SEGRE_DMMU_WB_FWD_EN
    assign fwd_hit_s = wb_valid_r && (wb_addr_r == miss_addr_r);
`else
    assign fwd_hit_s = 1'b0;
`endif

    // Next-state decode; a buffered writeback always wins over a new fill in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wb_valid_r) begin
                    state_s = ST_WB;
                end else if (miss_i) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (mem_ack_i) begin
                    state_s = miss_pend_r ? ST_FILL : ST_IDLE;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_FILL: begin
                if (fwd_hit_s || mem_ack_i) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Writeback buffer: capture when empty, release on the write acknowledge.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            wb_valid_r <= 1'b0;
            wb_addr_r  <= '0;
            wb_data_r  <= '0;
        end else if (state_r == ST_WB && mem_ack_i) begin
            wb_valid_r <= 1'b0;
        end else if (wb_i && !wb_valid_r) begin
            wb_valid_r <= 1'b1;
            wb_addr_r  <= wb_addr_i & ALIGN_MASK;
            wb_data_r  <= wb_data_i;
        end
    end

    // Miss latch: taken on any IDLE decision with miss_i so a fill can follow the drain.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            miss_addr_r <= '0;
            miss_pend_r <= 1'b0;
        end else if (state_r == ST_IDLE && miss_i) begin
            miss_addr_r <= miss_addr_i & ALIGN_MASK;
            miss_pend_r <= 1'b1;
        end else if (state_r == ST_RESP) begin
            miss_pend_r <= 1'b0;
        end
    end

    // Response registers hold the last filled line after the strobe.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            resp_addr_r <= '0;
            resp_data_r <= '0;
        end else if (state_r == ST_FILL && state_s == ST_RESP) begin
            resp_addr_r <= miss_addr_r;
            resp_data_r <= fwd_hit_s ? wb_data_r : mem_rd_data_i;
        end
    end

    // Round-robin victim counter, advanced once per response.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            victim_r <= '0;
        end else if (state_r == ST_RESP) begin
            victim_r <= victim_r + INDEX_W'(1);
        end
    end

    assign wb_ready_o    = !wb_valid_r;
    assign busy_o        = (state_r != ST_IDLE);
    assign data_rdy_o    = (state_r == ST_RESP);
    assign addr_o        = resp_addr_r;
    assign data_o        = resp_data_r;
    assign lru_index_o   = (state_r == ST_RESP) ? victim_r : '0;
    assign mem_wr_req_o  = (state_r == ST_WB);
    assign mem_rd_req_o  = (state_r == ST_FILL) && !fwd_hit_s;
    assign mem_addr_o    = (state_r == ST_WB)   ? wb_addr_r :
                           (state_r == ST_FILL) ? miss_addr_r : '0;
    assign mem_wr_data_o = (state_r == ST_WB)   ? wb_data_r : '0;

endmodule

// File: tb/tb_segre_dmmu_responder.sv
// Directed bench for segre_dmmu_responder: table of fill vectors plus hand-written multi-cycle sequences.
// Honours SEGRE_DMMU_WB_FWD_EN to select the expected forwarding behaviour.
module tb_segre_dmmu_responder;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b1;
    logic         miss_i = 1'b0;
    logic [31:0]  miss_addr_i = 32'h0;
    logic         wb_i = 1'b0;
    logic [31:0]  wb_addr_i = 32'h0;
    logic [127:0] wb_data_i = 128'h0;
    logic         wb_ready_o;
    logic         data_rdy_o;
    logic [31:0]  addr_o;
    logic [127:0] data_o;
    logic [1:0]   lru_index_o;
    logic         busy_o;
    logic         mem_rd_req_o;
    logic         mem_wr_req_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wr_data_o;
    logic         mem_ack_i = 1'b0;
    logic [127:0] mem_rd_data_i = 128'h0;

    int checks = 0;
    int failures = 0;
    int overlap = 0;

    typedef struct {
        logic [31:0]  addr;
        int           k;
        logic [127:0] data;
        logic [31:0]  exp_addr;
        logic [1:0]   exp_lru;
    } miss_vec_t;

    miss_vec_t vecs[5];

    segre_dmmu_responder dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .miss_i(miss_i), .miss_addr_i(miss_addr_i),
        .wb_i(wb_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_ready_o(wb_ready_o),
        .data_rdy_o(data_rdy_o), .addr_o(addr_o), .data_o(data_o), .lru_index_o(lru_index_o),
        .busy_o(busy_o), .mem_rd_req_o(mem_rd_req_o), .mem_wr_req_o(mem_wr_req_o),
        .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_ack_i(mem_ack_i), .mem_rd_data_i(mem_rd_data_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Flag any cycle with both memory requests raised.
    always @(negedge clk_i) begin
        if (mem_rd_req_o && mem_wr_req_o) overlap++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk1({tag, "_wb_ready"}, wb_ready_o, 1'b1);
        chk1({tag, "_data_rdy"}, data_rdy_o, 1'b0);
        chka({tag, "_addr"}, addr_o, 32'h0);
        chkd({tag, "_data"}, data_o, 128'h0);
        chka({tag, "_lru"}, {30'd0, lru_index_o}, 32'h0);
        chk1({tag, "_busy"}, busy_o, 1'b0);
        chk1({tag, "_rd_req"}, mem_rd_req_o, 1'b0);
        chk1({tag, "_wr_req"}, mem_wr_req_o, 1'b0);
        chka({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chkd({tag, "_wr_data"}, mem_wr_data_o, 128'h0);
    endtask

    // Single fill with an empty buffer; ack arrives k cycles after the miss is raised.
    task automatic run_miss(input miss_vec_t v);
        miss_i = 1'b1;
        miss_addr_i = v.addr;
        tick();
        chk1("fill_rd_req", mem_rd_req_o, 1'b1);
        chk1("fill_wr_req", mem_wr_req_o, 1'b0);
        chka("fill_mem_addr", mem_addr_o, v.exp_addr);
        chk1("fill_busy", busy_o, 1'b1);
        repeat (v.k - 1) begin
            chk1("fill_no_rdy", data_rdy_o, 1'b0);
            tick();
        end
        mem_ack_i = 1'b1;
        mem_rd_data_i = v.data;
        tick();
        mem_ack_i = 1'b0;
        mem_rd_data_i = 128'h0;
        chk1("resp_rdy", data_rdy_o, 1'b1);
        chka("resp_addr", addr_o, v.exp_addr);
        chkd("resp_data", data_o, v.data);
        chka("resp_lru", {30'd0, lru_index_o}, {30'd0, v.exp_lru});
        chk1("resp_rd_req", mem_rd_req_o, 1'b0);
        miss_i = 1'b0;
        tick();
        chk1("post_rdy", data_rdy_o, 1'b0);
        chkd("post_data_hold", data_o, v.data);
        chk1("post_busy", busy_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h0000_1234, 3, {16{8'hA5}}, 32'h0000_1230, 2'd0};
        vecs[1] = '{32'h0000_100F, 1, {4{32'hCAFE_F00D}}, 32'h0000_1000, 2'd1};
        vecs[2] = '{32'hFFFF_FFFF, 2, {8{16'h1357}}, 32'hFFFF_FFF0, 2'd2};
        vecs[3] = '{32'h8000_0010, 4, {2{64'h0123_4567_89AB_CDEF}}, 32'h8000_0010, 2'd3};
        vecs[4] = '{32'h0000_0007, 1, {16{8'h3C}}, 32'h0000_0000, 2'd0};

        // Reset state, both while held and after release.
        tick();
        tick();
        chk_reset_outs("rst_held");
        rsn_i = 1'b0;
        tick();
        chk_reset_outs("rst_rel");

        // Plain misses and victim wrap 0,1,2,3,0.
        for (int i = 0; i < 5; i++) run_miss(vecs[i]);

        // Writeback ordering: write to 0x2000 acked before the read of 0x3000.
        wb_i = 1'b1;
        wb_addr_i = 32'h0000_2000;
        wb_data_i = {16{8'h11}};
        tick();
        wb_i = 1'b0;
        chk1("wbo_full", wb_ready_o, 1'b0);
        miss_i = 1'b1;
        miss_addr_i = 32'h0000_3004;
        tick();
        chk1("wbo_wr_req", mem_wr_req_o, 1'b1);
        chk1("wbo_no_rd", mem_rd_req_o, 1'b0);
        chka("wbo_wr_addr", mem_addr_o, 32'h0000_2000);
        chkd("wbo_wr_data", mem_wr_data_o, {16{8'h11}});
        tick();
        chk1("wbo_wr_held", mem_wr_req_o, 1'b1);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk1("wbo_rd_req", mem_rd_req_o, 1'b1);
        chk1("wbo_wr_done", mem_wr_req_o, 1'b0);
        chka("wbo_rd_addr", mem_addr_o, 32'h0000_3000);
        chk1("wbo_empty", wb_ready_o, 1'b1);
        mem_ack_i = 1'b1;
        mem_rd_data_i = {16{8'h5A}};
        tick();
        mem_ack_i = 1'b0;
        chk1("wbo_rdy", data_rdy_o, 1'b1);
        chka("wbo_addr", addr_o, 32'h0000_3000);
        chkd("wbo_data", data_o, {16{8'h5A}});
        chka("wbo_lru", {30'd0, lru_index_o}, 32'd1);
        miss_i = 1'b0;
        tick();

        // Back-pressure: a held second writeback is accepted after the first write ack.
        wb_i = 1'b1;
        wb_addr_i = 32'h0000_5000;
        wb_data_i = {16{8'hD1}};
        tick();
        wb_addr_i = 32'h0000_6000;
        wb_data_i = {16{8'hD2}};
        chk1("bp_not_ready", wb_ready_o, 1'b0);
        tick();
        chka("bp_first_addr", mem_addr_o, 32'h0000_5000);
        chkd("bp_first_data", mem_wr_data_o, {16{8'hD1}});
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk1("bp_ready_after_ack", wb_ready_o, 1'b1);
        chk1("bp_idle", mem_wr_req_o, 1'b0);
        tick();
        wb_i = 1'b0;
        chk1("bp_second_captured", wb_ready_o, 1'b0);
        tick();
        chka("bp_second_addr", mem_addr_o, 32'h0000_6000);
        chkd("bp_second_data", mem_wr_data_o, {16{8'hD2}});
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk1("bp_drained", busy_o, 1'b0);

        // A stray ack in IDLE does nothing.
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk1("stray_ack_busy", busy_o, 1'b0);
        chk1("stray_ack_rdy", data_rdy_o, 1'b0);

        // Reset mid-FILL with a buffered writeback: everything is dropped.
        miss_i = 1'b1;
        miss_addr_i = 32'h0000_7000;
        wb_i = 1'b1;
        wb_addr_i = 32'h0000_9000;
        wb_data_i = {16{8'h77}};
        tick();
        wb_i = 1'b0;
        chk1("rf_rd_req", mem_rd_req_o, 1'b1);
        chk1("rf_buf_full", wb_ready_o, 1'b0);
        rsn_i = 1'b1;
        miss_i = 1'b0;
        tick();
        rsn_i = 1'b0;
        chk_reset_outs("rf");
        tick();
        tick();
        chk1("rf_no_rdy", data_rdy_o, 1'b0);
        chk1("rf_no_wb", busy_o, 1'b0);
        run_miss('{32'h0000_7040, 2, {16{8'h42}}, 32'h0000_7040, 2'd0});

        // Miss and writeback of the same line raised together.
        wb_i = 1'b1;
        wb_addr_i = 32'h0000_4000;
        wb_data_i = {8{16'hBEEF}};
        miss_i = 1'b1;
        miss_addr_i = 32'h0000_4008;
        tick();
        wb_i = 1'b0;
        chk1("fw_buf_full", wb_ready_o, 1'b0);
`ifdef SEGRE_DMMU_WB_FWD_EN
        chk1("fw_no_rd_req", mem_rd_req_o, 1'b0);
        tick();
        chk1("fw_rdy", data_rdy_o, 1'b1);
        chka("fw_addr", addr_o, 32'h0000_4000);
        chkd("fw_data", data_o, {8{16'hBEEF}});
`else
        chk1("fw_rd_req", mem_rd_req_o, 1'b1);
        chka("fw_rd_addr", mem_addr_o, 32'h0000_4000);
        mem_ack_i = 1'b1;
        mem_rd_data_i = {16{8'h33}};
        tick();
        mem_ack_i = 1'b0;
        chk1("fw_rdy", data_rdy_o, 1'b1);
        chka("fw_addr", addr_o, 32'h0000_4000);
        chkd("fw_data", data_o, {16{8'h33}});
`endif
        chka("fw_lru", {30'd0, lru_index_o}, 32'd1);
        miss_i = 1'b0;
        tick();
        chk1("fw_idle", busy_o, 1'b0);
        tick();
        chk1("fw_drain_wr", mem_wr_req_o, 1'b1);
        chka("fw_drain_addr", mem_addr_o, 32'h0000_4000);
        chkd("fw_drain_data", mem_wr_data_o, {8{16'hBEEF}});
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk1("fw_drained", wb_ready_o, 1'b1);

        chka("no_req_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
